// File: rtl/cipher_pio_bridge.sv
`default_nettype none
// cipher_pio_bridge: latches SoC PIO operands, pulses the cipher core start and captures its result (rev 1.0).
// Build macro CIPHER_TIMEOUT_EN adds a RUN-state watchdog that aborts the core and raises err.
module cipher_pio_bridge #(
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                soft_reset,
  input  logic [WORD_W-1:0]   block0,
  input  logic [WORD_W-1:0]   block1,
  input  logic [WORD_W-1:0]   block2,
  input  logic [WORD_W-1:0]   block3,
  input  logic [WORD_W-1:0]   key0,
  input  logic [WORD_W-1:0]   key1,
  input  logic [WORD_W-1:0]   key2,
  input  logic [WORD_W-1:0]   key3,
  input  logic                ende,
  input  logic                start,
  output logic                busy,
  output logic [WORD_W-1:0]   out0,
  output logic [WORD_W-1:0]   out1,
  output logic [WORD_W-1:0]   out2,
  output logic [WORD_W-1:0]   out3,
  output logic                core_reset,
  output logic                core_start,
  output logic                core_ende,
  output logic [4*WORD_W-1:0] core_block,
  output logic [4*WORD_W-1:0] core_key,
  input  logic                core_done,
  input  logic [4*WORD_W-1:0] core_result,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  start_q;
  logic                  ende_q;
  logic [4*WORD_W-1:0]   block_q;
  logic [4*WORD_W-1:0]   key_q;
  logic [4*WORD_W-1:0]   result_q;

  logic                  rst_any;
  logic                  start_edge;
  logic                  accept;
  logic                  capture;
  logic                  timeout;

  assign rst_any    = Reset | soft_reset;
  assign start_edge = start & ~start_q;
  assign accept     = (state == IDLE) & start_edge;
  // core_done is only meaningful once the core has actually been started
  assign capture    = (state == RUN) & core_done;

  always_ff @(posedge Clk) begin
    if (rst_any) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    core_start = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        busy       = 1'b1;
        core_start = 1'b1;
        state_nxt  = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (capture || timeout) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // start_q resets high so a start level held across reset is not seen as an edge
  always_ff @(posedge Clk) begin
    if (rst_any) begin
      start_q  <= 1'b1;
      ende_q   <= 1'b0;
      block_q  <= '0;
      key_q    <= '0;
      result_q <= '0;
    end else begin
      start_q <= start;
      if (accept) begin
        block_q <= {block0, block1, block2, block3};
        key_q   <= {key0, key1, key2, key3};
        ende_q  <= ende;
      end
      if (capture) begin
        result_q <= core_result;
      end else if (timeout) begin
        result_q <= '1;
      end
    end
  end

`ifdef CIPHER_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] run_cnt;
  logic             err_q;

  // run_cnt holds the number of RUN cycles already completed; a done in the
  // limit cycle takes priority over the abort
  assign timeout = (state == RUN) && !core_done && (run_cnt == CNT_LAST);

  always_ff @(posedge Clk) begin
    if (rst_any) begin
      run_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        run_cnt <= '0;
      end else if (state == RUN) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err        = err_q;
  assign core_reset = rst_any | timeout;
`else
  assign timeout    = 1'b0;
  // constant 0: the watchdog is not built
  assign err        = (TIMEOUT_CYCLES < 0);
  assign core_reset = rst_any;
`endif

  assign core_ende  = ende_q;
  assign core_block = block_q;
  assign core_key   = key_q;

  assign out0 = result_q[4*WORD_W-1 -: WORD_W];
  assign out1 = result_q[3*WORD_W-1 -: WORD_W];
  assign out2 = result_q[2*WORD_W-1 -: WORD_W];
  assign out3 = result_q[WORD_W-1:0];

endmodule
`default_nettype wire

// File: doc/cipher_pio_bridge.md
Name: cipher_pio_bridge

Overview:
- Sits directly downstream of the NIOS SoC PIO exports and upstream of the 128-bit block-cipher core.
- Turns software-driven PIO levels (block0..3, key0..3, ende, start) into a latched operand set and a one-cycle core start pulse.
- Captures the core result into out0..3 and drives busy back to the SoC, so software can poll busy and then read results.

Parameters:
- WORD_W, 32, width of each PIO word.
- TIMEOUT_CYCLES, 4096, RUN-state watchdog limit (used only with CIPHER_TIMEOUT_EN).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- soft_reset  in  1  SoC reset_1 PIO; treated identically to Reset.
- block0..block3  in  WORD_W each  plaintext/ciphertext words from SoC.
- key0..key3  in  WORD_W each  key words from SoC.
- ende  in  1  operation select: 1 = encrypt, 0 = decrypt.
- start  in  1  software start level.
- busy  out  1  to SoC busy PIO.
- out0..out3  out  WORD_W each  result words to SoC.
- core_reset  out  1  combinational Reset | soft_reset, and a timeout abort pulse when CIPHER_TIMEOUT_EN is defined.
- core_start  out  1  one-cycle start pulse to the core.
- core_ende  out  1  latched ende.
- core_block  out  4*WORD_W  latched block.
- core_key  out  4*WORD_W  latched key.
- core_done  in  1  one-cycle completion pulse from the core.
- core_result  in  4*WORD_W  core output; valid only while core_done=1.
- err  out  1  timeout flag.

Behaviour:
- Word packing:
  - block0 maps to core_block[127:96], block3 to [31:0].
  - key and result use the same packing; out0 = core_result[127:96].
- Reset (Reset or soft_reset high at a clock edge):
  - state=IDLE; busy=0, core_start=0, err=0.
  - out0..3=0; operand registers=0.
  - start_q=1, so a start held high across reset does not fire.
- start_q: registered copy of start, updated every cycle in every state. Edge = start & ~start_q.
- IDLE:
  - busy=0.
  - On an edge, in the same cycle: latch block, key and ende into the operand registers; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - busy=1, core_start=1; go to RUN.
  - core_done is ignored in this cycle.
- RUN:
  - busy=1, core_start=0.
  - On core_done=1: register core_result into out0..3; go to IDLE. busy=0 from the next cycle.
- Latency:
  - Edge sampled at cycle 0.
  - busy=1 and core_start=1 at cycle 1.
  - Result visible and busy=0 one cycle after the core_done cycle.
- Edges while busy=1 are ignored, not queued. start_q still tracks, so a start held high through completion never retriggers. Software must drop start and raise it again.
- PIO operand changes while busy=1 do not reach the core; core_* holds the latched values.
- out0..3 hold their value until the next capture. They are not cleared by a new start.
- A core_done in IDLE is ignored; out registers are unchanged.
- Reset during ISSUE/RUN: abort to IDLE with the reset values above. core_reset is asserted the same cycle.

Optional Feature:
- Macro: CIPHER_TIMEOUT_EN.
- When defined:
  - A 13-bit (clog2 TIMEOUT_CYCLES + 1) counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES with no core_done: out0..3 = 32'hFFFFFFFF, err=1, core_reset=1 for one cycle, state=IDLE.
  - err is sticky and clears on the next accepted edge or reset.
  - core_done in the same cycle as the limit wins (normal capture, err=0).
- When undefined: no counter; RUN waits indefinitely; err tied to 0.

Test Plan:
1. Reset, then block0..3=00112233/44556677/8899AABB/CCDDEEFF, key=0, ende=1, start 0→1; core model returns done after 16 cycles with result 0123456789ABCDEF_FEDCBA9876543210.
   - Expect core_start one pulse at cycle 1, busy=1 from cycle 1 to the done cycle.
   - Expect core_block=00112233_..._CCDDEEFF and core_ende=1.
   - Expect out0=01234567, out3=76543210 and busy=0 the cycle after done.
2. Hold start=1 after completion for 50 cycles.
   - Expect no second core_start.
   - Then start 0→1: exactly one new core_start.
3. Change block0 to DEADBEEF and pulse start again during RUN.
   - Expect core_block unchanged, no extra core_start, busy timing unchanged.
4. Assert soft_reset for 1 cycle mid-RUN.
   - Expect busy=0, out0..3=0, core_reset=1 that cycle.
   - A late core_done is ignored.
   - Start held high through the reset does not trigger.
5. Assert core_done during ISSUE, then again 3 cycles later.
   - Expect only the second pulse captured.
6. With CIPHER_TIMEOUT_EN, TIMEOUT_CYCLES=8 and a core that never responds:
   - Expect after 8 RUN cycles: out0..3=FFFFFFFF, err=1, one core_reset pulse, busy=0.
   - The next start edge clears err.
